// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between the fetch side, the decode stage and the control ROM side.
// slave is the decode stage's view; master is the view of whoever drives it.
interface instr_decode_stage_if #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 8
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               dec_valid;
    logic [63:0]        dec_onehot;
    logic [INSTR_W-7:0] dec_operand;
    logic               dec_illegal;
    logic               dec_ready;
    logic [CNT_W-1:0]   illegal_count;

    modport slave (
        input  instr_valid, instr, dec_ready,
        output instr_ready, dec_valid, dec_onehot, dec_operand, dec_illegal, illegal_count
    );

    modport master (
        output instr_valid, instr, dec_ready,
        input  instr_ready, dec_valid, dec_onehot, dec_operand, dec_illegal, illegal_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Decodes 6-bit opcodes to a one-hot control-ROM word at enqueue and buffers
// up to two decoded instructions; counts consumed illegal opcodes (saturating).
module instr_decode_stage #(
    parameter int          INSTR_W    = 32,
    parameter logic [63:0] LEGAL_MASK = 64'h0800_0000_0200_7010,
    parameter int          CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    instr_decode_stage_if.slave   bus
);
    localparam int OP_W = INSTR_W - 6;

    logic [1:0][63:0]     onehot_q;
    logic [1:0][OP_W-1:0] operand_q;
    logic [1:0]           illegal_q;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count;
    logic [CNT_W-1:0]     ill_cnt;

    logic [5:0]      opcode;
    logic            legal;
    logic [63:0]     onehot_d;
    logic            push, pop;

    assign opcode   = bus.instr[INSTR_W-1 -: 6];
    assign legal    = LEGAL_MASK[opcode];
    assign onehot_d = legal ? (64'd1 << opcode) : 64'd0;

    // Ready depends only on registered occupancy, never on downstream ready.
    assign bus.instr_ready = (count < 2'd2);
    assign bus.dec_valid   = (count != 2'd0);
    assign push = bus.instr_valid & bus.instr_ready;
    assign pop  = bus.dec_valid & bus.dec_ready;

    assign bus.dec_onehot    = bus.dec_valid ? onehot_q[rd_ptr]  : 64'd0;
    assign bus.dec_operand   = bus.dec_valid ? operand_q[rd_ptr] : '0;
    assign bus.dec_illegal   = bus.dec_valid ? illegal_q[rd_ptr] : 1'b0;
    assign bus.illegal_count = ill_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot_q  <= '0;
            operand_q <= '0;
            illegal_q <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            ill_cnt   <= '0;
        end else if (flush) begin
            // Flush drops everything in flight, including a same-cycle push or pop.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                onehot_q[wr_ptr]  <= onehot_d;
                operand_q[wr_ptr] <= bus.instr[OP_W-1:0];
                illegal_q[wr_ptr] <= ~legal;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (illegal_q[rd_ptr] && !(&ill_cnt))
                    ill_cnt <= ill_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode, ordering, backpressure,
// illegal counting/saturation, flush and mid-stream reset.
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst_n, flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.INSTR_W(32), .CNT_W(8)) bus ();

    instr_decode_stage #(.INSTR_W(32), .LEGAL_MASK(64'h0800_0000_0200_7010), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] opnd);
        return {op, opnd};
    endfunction

    initial begin
        logic [5:0]  sweep_op [5] = '{6'd25, 6'd12, 6'd13, 6'd14, 6'd59};
        logic [63:0] sweep_oh [5] = '{64'h0200_0000, 64'h1000, 64'h2000, 64'h4000,
                                      64'h0800_0000_0000_0000};

        rst_n = 1'b0; flush = 1'b0;
        bus.instr_valid = 1'b0; bus.instr = '0; bus.dec_ready = 1'b0;
        step(); step();
        chk("rst_dec_valid", bus.dec_valid, 0);
        chk("rst_instr_ready", bus.instr_ready, 1);
        chk("rst_onehot", bus.dec_onehot, 0);
        chk("rst_operand", bus.dec_operand, 0);
        chk("rst_illegal", bus.dec_illegal, 0);
        chk("rst_ill_cnt", bus.illegal_count, 0);

        // Single Add with one-cycle latency
        rst_n = 1'b1;
        bus.dec_ready = 1'b1; bus.instr_valid = 1'b1; bus.instr = mk(6'd4, 26'h123);
        step();
        bus.instr_valid = 1'b0;
        chk("add_valid", bus.dec_valid, 1);
        chk("add_onehot", bus.dec_onehot, 64'h10);
        chk("add_illegal", bus.dec_illegal, 0);
        chk("add_operand", bus.dec_operand, 26'h123);
        step();
        chk("add_drained", bus.dec_valid, 0);
        chk("idle_onehot", bus.dec_onehot, 0);
        step();
        chk("idle_pop_noop", bus.dec_valid, 0);

        // Back-to-back opcode sweep at one per cycle
        for (int i = 0; i < 5; i++) begin
            bus.instr_valid = 1'b1; bus.instr = mk(sweep_op[i], 26'(i));
            step();
            chk($sformatf("sweep_onehot_%0d", i), bus.dec_onehot, sweep_oh[i]);
            chk($sformatf("sweep_ready_%0d", i), bus.instr_ready, 1);
        end
        bus.instr_valid = 1'b0;
        step();
        chk("sweep_drained", bus.dec_valid, 0);

        // Backpressure: fill, hold third, then drain in order
        bus.dec_ready = 1'b0;
        bus.instr_valid = 1'b1; bus.instr = mk(6'd4, 26'h1);
        step();
        bus.instr = mk(6'd25, 26'h2);
        step();
        chk("bp_full_ready", bus.instr_ready, 0);
        chk("bp_head", bus.dec_onehot, 64'h10);
        bus.instr = mk(6'd12, 26'h3);
        step();
        chk("bp_held_ready", bus.instr_ready, 0);
        chk("bp_head_stable", bus.dec_onehot, 64'h10);
        chk("bp_operand_stable", bus.dec_operand, 26'h1);
        bus.dec_ready = 1'b1;
        step();
        chk("bp_second", bus.dec_onehot, 64'h0200_0000);
        chk("bp_ready_back", bus.instr_ready, 1);
        step();
        bus.instr_valid = 1'b0;
        chk("bp_third", bus.dec_onehot, 64'h1000);
        chk("bp_third_operand", bus.dec_operand, 26'h3);
        step();
        chk("bp_drained", bus.dec_valid, 0);

        // Illegal opcode
        bus.dec_ready = 1'b0;
        bus.instr_valid = 1'b1; bus.instr = mk(6'd1, 26'h3FF_FFFF);
        step();
        bus.instr_valid = 1'b0;
        chk("ill_onehot", bus.dec_onehot, 0);
        chk("ill_flag", bus.dec_illegal, 1);
        chk("ill_operand", bus.dec_operand, 26'h3FF_FFFF);
        chk("ill_cnt_before", bus.illegal_count, 0);
        bus.dec_ready = 1'b1;
        step();
        chk("ill_cnt_after", bus.illegal_count, 1);
        chk("ill_drained", bus.dec_valid, 0);

        // Flush with full FIFO of illegals and a pop offered
        bus.dec_ready = 1'b0;
        bus.instr_valid = 1'b1; bus.instr = mk(6'd1, 26'h0);
        step(); step();
        chk("fl_full", bus.instr_ready, 0);
        flush = 1'b1; bus.dec_ready = 1'b1; bus.instr = mk(6'd4, 26'h5);
        step();
        flush = 1'b0; bus.instr_valid = 1'b0; bus.dec_ready = 1'b0;
        chk("fl_valid", bus.dec_valid, 0);
        chk("fl_ready", bus.instr_ready, 1);
        chk("fl_onehot", bus.dec_onehot, 0);
        chk("fl_ill_cnt", bus.illegal_count, 1);
        // Flush drops a push that was accepted by ready
        bus.instr_valid = 1'b1; bus.instr = mk(6'd4, 26'h6);
        step();
        flush = 1'b1; bus.instr = mk(6'd25, 26'h7);
        step();
        flush = 1'b0; bus.instr_valid = 1'b0;
        chk("fl_push_dropped", bus.dec_valid, 0);
        step();
        chk("fl_still_empty", bus.dec_valid, 0);

        // Saturation: 1 already counted; stream illegals with dec_ready high
        bus.dec_ready = 1'b1;
        bus.instr_valid = 1'b1; bus.instr = mk(6'd63, 26'h0);
        for (int i = 0; i < 254; i++) step();
        chk("sat_254", bus.illegal_count, 254);
        for (int i = 0; i < 46; i++) step();
        bus.instr_valid = 1'b0;
        step();
        chk("sat_255", bus.illegal_count, 255);
        chk("sat_drained", bus.dec_valid, 0);

        // Reset mid-stream with two entries held
        bus.dec_ready = 1'b0;
        bus.instr_valid = 1'b1; bus.instr = mk(6'd4, 26'h8);
        step();
        bus.instr = mk(6'd25, 26'h9);
        step();
        bus.instr_valid = 1'b0;
        chk("mid_full", bus.instr_ready, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", bus.dec_valid, 0);
        chk("mid_rst_onehot", bus.dec_onehot, 0);
        chk("mid_rst_ill_cnt", bus.illegal_count, 0);
        chk("mid_rst_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1; bus.instr = mk(6'd59, 26'hA);
        step();
        bus.instr_valid = 1'b0;
        chk("post_rst_valid", bus.dec_valid, 1);
        chk("post_rst_onehot", bus.dec_onehot, 64'h0800_0000_0000_0000);
        chk("post_rst_operand", bus.dec_operand, 26'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
